// File: rtl/fp16div_if.sv
// Valid/ready handshake bundle for the fp16div sequential divider.
// The operand side is driven by the master. The result side is driven by the slave.
interface fp16div_if;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_a;
    logic [15:0] i_b;
    logic        o_valid;
    logic [15:0] o_res;
    logic        i_ready;

    modport master (
        output i_valid, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_res
    );

    modport slave (
        input  i_valid, i_a, i_b, i_ready,
        output o_ready, o_valid, o_res
    );
endinterface

// File: rtl/fp16div.sv
// Sequential binary16 divider: DAZ inputs, FTZ outputs, round toward zero.
// The quotient significand comes from a restoring divider that produces one bit per clock.
module fp16div (
    input  logic     i_clk,
    input  logic     i_rst,
    fp16div_if.slave bus
);
    localparam logic signed [6:0] BIAS = 7'sd15;
    localparam logic [15:0]       QNAN = 16'h7E00;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
    typedef enum logic [1:0] {CL_ZERO, CL_NORM, CL_INF, CL_NAN} cls_t;

    function automatic cls_t daz_class(input logic [15:0] x);
        if (x[14:10] == 5'h1F) return (x[9:0] != 10'h000) ? CL_NAN : CL_INF;
        if (x[14:10] == 5'h00) return CL_ZERO;
        return CL_NORM;
    endfunction

    // Saturate exponent overflow to Inf and flush underflow to signed zero.
    function automatic logic [15:0] ftz_encode(input logic sign,
                                               input logic signed [6:0] exp,
                                               input logic [9:0] man);
        if (exp <= 7'sd0)  return {sign, 15'h0000};
        if (exp >= 7'sd31) return {sign, 5'h1F, 10'h000};
        return {sign, exp[4:0], man};
    endfunction

    function automatic logic [15:0] special_res(input cls_t ca, input cls_t cb, input logic sign);
        if (ca == CL_NAN || cb == CL_NAN)                             return QNAN;
        if ((ca == CL_INF && cb == CL_INF) || (ca == CL_ZERO && cb == CL_ZERO)) return QNAN;
        if (ca == CL_INF || cb == CL_ZERO)                            return {sign, 5'h1F, 10'h000};
        return {sign, 15'h0000};
    endfunction

    state_t             state_q, state_d;
    logic [15:0]        res_q, res_d;
    logic [11:0]        rem_q, rem_d;
    logic [10:0]        div_q, div_d;
    logic [10:0]        quo_q, quo_d;
    logic signed [6:0]  exp_q, exp_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               sign_q, sign_d;

    cls_t               cls_a, cls_b;
    logic               sign_in;
    logic               qbit;
    logic [10:0]        rem_sub;
    logic [11:0]        quo_nxt;

    assign cls_a   = daz_class(bus.i_a);
    assign cls_b   = daz_class(bus.i_b);
    assign sign_in = bus.i_a[15] ^ bus.i_b[15];
    // The remainder is always below 2*d, so the difference fits in 11 bits.
    assign qbit    = (rem_q >= {1'b0, div_q});
    assign rem_sub = qbit ? (rem_q[10:0] - div_q) : rem_q[10:0];
    assign quo_nxt = {quo_q, qbit};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            res_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    always_ff @(posedge i_clk) begin
        rem_q  <= rem_d;
        div_q  <= div_d;
        quo_q  <= quo_d;
        exp_q  <= exp_d;
        cnt_q  <= cnt_d;
        sign_q <= sign_d;
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    sign_d = sign_in;
                    if (cls_a == CL_NORM && cls_b == CL_NORM) begin
                        rem_d   = {2'b01, bus.i_a[9:0]};
                        div_d   = {1'b1, bus.i_b[9:0]};
                        quo_d   = 11'h000;
                        exp_d   = $signed({2'b00, bus.i_a[14:10]}) - $signed({2'b00, bus.i_b[14:10]}) + BIAS;
                        cnt_d   = 4'd11;
                        state_d = DIV;
                    end else begin
                        res_d   = special_res(cls_a, cls_b, sign_in);
                        state_d = DONE;
                    end
                end
            end
            DIV: begin
                rem_d = {rem_sub, 1'b0};
                quo_d = quo_nxt[10:0];
                cnt_d = cnt_q - 4'd1;
                // Finalize on the last quotient bit; leftover remainder is truncated.
                if (cnt_q == 4'd0) begin
                    res_d   = quo_nxt[11] ? ftz_encode(sign_q, exp_q, quo_nxt[10:1])
                                          : ftz_encode(sign_q, exp_q - 7'sd1, quo_nxt[9:0]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_ready = (state_q == IDLE);
        bus.o_valid = (state_q == DONE);
        bus.o_res   = res_q;
    end
endmodule

// File: tb/tb_fp16div.sv
// Directed and randomized bench for fp16div.
// Expected values are hand-computed vectors plus a real-arithmetic reference for random operands.
module tb_fp16div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    fp16div_if bus ();

    fp16div dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
    endfunction

    // Reference divide: DAZ, RTZ, FTZ. NaN is returned as 7E00 and compared by class only.
    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
        int  ea, eb, e, frac;
        real m;
        logic s, an, bn, ai, bi, az, bz;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        s  = a[15] ^ b[15];
        an = (ea == 31) && (a[9:0] != 0);
        bn = (eb == 31) && (b[9:0] != 0);
        ai = (ea == 31) && (a[9:0] == 0);
        bi = (eb == 31) && (b[9:0] == 0);
        az = (ea == 0);
        bz = (eb == 0);
        if (an || bn || (ai && bi) || (az && bz)) return 16'h7E00;
        if (ai || bz) return {s, 5'h1F, 10'h000};
        if (az || bi) return {s, 15'h0000};
        m = real'(1024 + int'(a[9:0])) / real'(1024 + int'(b[9:0]));
        e = ea - eb + 15;
        if (m < 1.0) begin
            m = m * 2.0;
            e = e - 1;
        end
        if (e <= 0) return {s, 15'h0000};
        if (e >= 31) return {s, 5'h1F, 10'h000};
        frac = int'($floor((m - 1.0) * 1024.0));
        return {s, e[4:0], frac[9:0]};
    endfunction

    // Presents one operand pair with i_ready high and returns the result and the edges from accept to o_valid.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output int lat);
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        step();
        bus.i_valid = 1'b0;
        lat = 0;
        while (!bus.o_valid && lat < 40) begin
            step();
            lat++;
        end
        if (lat >= 40) lat = -1;
        res = bus.o_res;
        step();
    endtask

    task automatic test_reset();
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_a     = 16'h0;
        bus.i_b     = 16'h0;
        #1;
        checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL reset_o_ready got=%b exp=1", bus.o_ready); end
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o_res !== 16'h0000) begin failures++; $display("FAIL reset_o_res got=%h exp=0000", bus.o_res); end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [15:0] r;
        int lat;
        do_op(16'h3C00, 16'h4200, r, lat);
        checks++; if (r !== 16'h3555) begin failures++; $display("FAIL basic_1_div_3 got=%h exp=3555", r); end
        do_op(16'h4200, 16'h3C00, r, lat);
        checks++; if (r !== 16'h4200) begin failures++; $display("FAIL basic_3_div_1 got=%h exp=4200", r); end
        checks++; if (lat != 12) begin failures++; $display("FAIL basic_latency got=%0d exp=12", lat); end
        checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_after got=%b exp=1", bus.o_ready); end
        do_op(16'hC000, 16'h4000, r, lat);
        checks++; if (r !== 16'hBC00) begin failures++; $display("FAIL basic_neg got=%h exp=BC00", r); end
    endtask

    task automatic test_range();
        logic [15:0] r;
        int lat;
        do_op(16'h7BFF, 16'h1400, r, lat);
        checks++; if (r !== 16'h7C00) begin failures++; $display("FAIL range_overflow got=%h exp=7C00", r); end
        do_op(16'h0400, 16'h4000, r, lat);
        checks++; if (r !== 16'h0000) begin failures++; $display("FAIL range_ftz got=%h exp=0000", r); end
        do_op(16'h0001, 16'h3C00, r, lat);
        checks++; if (r !== 16'h0000) begin failures++; $display("FAIL range_daz got=%h exp=0000", r); end
    endtask

    task automatic test_specials();
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic [15:0] ve [6];
        logic [15:0] r;
        int lat;
        va = '{16'h4000, 16'hC000, 16'h3C00, 16'h0000, 16'h7C00, 16'h7E00};
        vb = '{16'h0000, 16'h0000, 16'h7C00, 16'h0000, 16'h7C00, 16'h3C00};
        ve = '{16'h7C00, 16'hFC00, 16'h0000, 16'h7E00, 16'h7E00, 16'h7E00};
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], r, lat);
            checks++;
            if (i >= 3) begin
                if (!is_nan(r)) begin failures++; $display("FAIL special_nan_%0d got=%h exp=NaN", i, r); end
            end else if (r !== ve[i]) begin
                failures++; $display("FAIL special_%0d got=%h exp=%h", i, r, ve[i]);
            end
            checks++; if (lat != 0) begin failures++; $display("FAIL special_latency_%0d got=%0d exp=0", i, lat); end
        end
    endtask

    task automatic test_back_pressure();
        int n;
        bus.i_a     = 16'h4200;
        bus.i_b     = 16'h3C00;
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b0;
        step();
        bus.i_valid = 1'b0;
        n = 0;
        while (!bus.o_valid && n < 40) begin step(); n++; end
        checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL bp_timeout got=%b exp=1", bus.o_valid); end
        for (int i = 0; i < 5; i++) begin
            bus.i_valid = i[0];
            bus.i_a     = 16'h3C00;
            bus.i_b     = 16'h0000;
            step();
            checks++;
            if (bus.o_res !== 16'h4200 || bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d got res=%h vld=%b rdy=%b exp res=4200 vld=1 rdy=0",
                         i, bus.o_res, bus.o_valid, bus.o_ready);
            end
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        step();
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_retire got vld=%b rdy=%b exp vld=0 rdy=1", bus.o_valid, bus.o_ready);
        end
    endtask

    task automatic test_reset_mid_div();
        logic [15:0] r;
        int lat;
        int seen;
        bus.i_a     = 16'h3C00;
        bus.i_b     = 16'h4200;
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        step();
        bus.i_valid = 1'b0;
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_res !== 16'h0000) begin
            failures++;
            $display("FAIL rst_async got rdy=%b vld=%b res=%h exp rdy=1 vld=0 res=0000",
                     bus.o_ready, bus.o_valid, bus.o_res);
        end
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.o_valid) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL rst_dropped got=%0d pulses exp=0", seen); end
        do_op(16'h4200, 16'h3C00, r, lat);
        checks++; if (r !== 16'h4200 || lat != 12) begin failures++; $display("FAIL rst_recover got res=%h lat=%0d exp res=4200 lat=12", r, lat); end
    endtask

    task automatic test_random();
        logic [15:0] a, b, r, e;
        int n;
        for (int k = 0; k < 400; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a[14:10] = ($urandom_range(0, 1) == 1) ? 5'h1F : 5'h00;
            if ($urandom_range(0, 7) == 0) b[14:10] = ($urandom_range(0, 1) == 1) ? 5'h1F : 5'h00;
            e = model(a, b);
            repeat ($urandom_range(0, 2)) step();
            bus.i_a     = a;
            bus.i_b     = b;
            bus.i_valid = 1'b1;
            bus.i_ready = 1'b0;
            step();
            bus.i_valid = 1'b0;
            bus.i_a     = 16'($urandom);
            n = 0;
            while (!bus.o_valid && n < 40) begin step(); n++; end
            repeat ($urandom_range(0, 3)) step();
            r = bus.o_res;
            checks++;
            if (!bus.o_valid) begin
                failures++; $display("FAIL rand_timeout_%0d a=%h b=%h", k, a, b);
            end else if (is_nan(e) ? !is_nan(r) : (r !== e)) begin
                failures++; $display("FAIL rand_%0d a=%h b=%h got=%h exp=%h", k, a, b, r, e);
            end
            bus.i_ready = 1'b1;
            step();
            bus.i_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_range();
        test_specials();
        test_back_pressure();
        test_reset_mid_div();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
